// File: rtl/handshake_pkg.sv
// Shared types and constants for the four-phase request/acknowledge transmit controller.
//   state_e         : controller states with fixed encoding
//   DEFAULT_DATA_W  : default payload width
//   DEFAULT_TIMEOUT : default per-phase wait limit in cycles
//   CNT_W           : width of the per-phase wait counter
package handshake_pkg;

    localparam int unsigned DEFAULT_DATA_W  = 8;
    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned CNT_W           = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_HI  = 2'd1,
        WAIT_LO = 2'd2,
        ERR_REL = 2'd3
    } state_e;

endpackage

// File: rtl/hs_timer.sv
// Clearable per-phase wait counter with a terminal-count compare.
//   clk, rst_n : clock and synchronous active-low reset
//   clr_i      : clear the counter (takes priority over en_i)
//   en_i       : count one waiting cycle
//   tc_c_o     : counter currently equals TIMEOUT-1 (decoded from the register)
module hs_timer
    import handshake_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_c_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/handshake_tx_ctrl.sv
// Transmit side of a four-phase req/ack handshake toward another clock domain.
//   clk, rst_n : clock and synchronous active-low reset
//   in_valid   : requester offers in_data
//   in_data    : payload, captured on acceptance only
//   in_ready   : controller can accept this cycle (IDLE and ack low, not in reset)
//   t_rdy_out  : registered request level toward the receive domain
//   data_out   : captured payload, stable while t_rdy_out is high
//   r_done_in  : acknowledge, already synchronized into clk
//   done       : one-cycle pulse when a handshake completes
//   err        : sticky per-phase timeout flag
//   clr_err    : clears err on the next edge
module handshake_tx_ctrl
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              t_rdy_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              r_done_in,
    output logic              done,
    output logic              err,
    input  logic              clr_err
);

    state_e            state_q;
    state_e            state_d;
    logic              t_rdy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;

    logic              accept_c;
    logic              complete_c;
    logic              timeout_c;
    logic              tc_c;
    logic              waiting_c;

    // Pure decode of state and the synchronized ack; reset forces it low.
    assign in_ready  = rst_n & (state_q == IDLE) & ~r_done_in;
    assign waiting_c = (state_q == REQ_HI) | (state_q == WAIT_LO);

    // Next state and event strobes; an advancing ack beats a coincident timeout.
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        complete_c = 1'b0;
        timeout_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept_c = 1'b1;
                    state_d  = REQ_HI;
                end
            end
            REQ_HI: begin
                if (r_done_in) begin
                    state_d = WAIT_LO;
                end else if (tc_c) begin
                    timeout_c = 1'b1;
                    state_d   = ERR_REL;
                end
            end
            WAIT_LO: begin
                if (!r_done_in) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end else if (tc_c) begin
                    timeout_c = 1'b1;
                    state_d   = ERR_REL;
                end
            end
            ERR_REL: begin
                if (!r_done_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, request level, payload, done pulse and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            t_rdy_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            t_rdy_q <= (state_d == REQ_HI);
            done_q  <= complete_c;
            if (accept_c) begin
                data_q <= in_data;
            end
            if (timeout_c) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    // Wait counter restarts on every state change and counts only while waiting.
    hs_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_d != state_q),
        .en_i   (waiting_c),
        .tc_c_o (tc_c)
    );

    assign t_rdy_out = t_rdy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign data_out  = data_q;

endmodule

// File: tb/tb_handshake_tx_ctrl.sv
module tb_handshake_tx_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMEOUT = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              in_valid  = 1'b0;
    logic [DATA_W-1:0] in_data   = '0;
    logic              in_ready;
    logic              t_rdy_out;
    logic [DATA_W-1:0] data_out;
    logic              r_done_in = 1'b0;
    logic              done;
    logic              err;
    logic              clr_err   = 1'b0;

    always #5 clk = ~clk;

    handshake_tx_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .t_rdy_out (t_rdy_out),
        .data_out  (data_out),
        .r_done_in (r_done_in),
        .done      (done),
        .err       (err),
        .clr_err   (clr_err)
    );

    int tests = 0;
    int fails = 0;

    // Protocol-level reference: a transfer is outstanding from acceptance until
    // the ack has risen and fallen again; each wait phase may last TIMEOUT edges.
    bit               m_out;       // transfer outstanding
    bit               m_acked;     // ack seen high for current transfer
    bit               m_rel;       // recovering from timeout, waiting for ack low
    bit               m_done;
    bit               m_err;
    bit               m_accept;
    int               m_age;       // edges spent in current wait phase
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] sb_q[$];
    int               done_seen = 0;
    int               acc_seen  = 0;

    int req_cnt = 0, rel_cnt = 0, req_dly = 1, rel_dly = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge with the current inputs, then compare all outputs.
    task automatic cycle();
        bit adv;
        bit to;
        logic [DATA_W-1:0] w;
        to       = 1'b0;
        m_done   = 1'b0;
        m_accept = 1'b0;
        if (!rst_n) begin
            if (m_out) void'(sb_q.pop_back());
            m_out = 0; m_acked = 0; m_rel = 0; m_err = 0; m_age = 0; m_data = '0;
        end else begin
            if (m_rel) begin
                if (!r_done_in) m_rel = 1'b0;
            end else if (!m_out) begin
                if (in_valid && !r_done_in) begin
                    m_out = 1'b1; m_acked = 1'b0; m_age = 0;
                    m_data = in_data; m_accept = 1'b1;
                    sb_q.push_back(in_data);
                    acc_seen++;
                end
            end else begin
                adv = m_acked ? !r_done_in : r_done_in;
                if (adv) begin
                    if (m_acked) begin
                        m_out = 1'b0; m_done = 1'b1;
                    end else begin
                        m_acked = 1'b1;
                    end
                    m_age = 0;
                end else if (m_age + 1 == int'(TIMEOUT)) begin
                    to = 1'b1; m_out = 1'b0; m_rel = 1'b1; m_age = 0;
                    void'(sb_q.pop_back());
                end else begin
                    m_age++;
                end
            end
            if (to) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
        @(posedge clk);
        #1;
        check("t_rdy_out", 32'(t_rdy_out), 32'(m_out && !m_acked));
        check("in_ready", 32'(in_ready), 32'(rst_n && !m_out && !m_rel && !r_done_in));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("data_out", 32'(data_out), 32'(m_data));
        if (done === 1'b1) begin
            done_seen++;
            check("sb_pending", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
                w = sb_q.pop_front();
                check("sb_word", 32'(data_out), 32'(w));
            end
        end
    endtask

    // Receive-side partner: raise ack after req_dly+1 cycles of request high,
    // drop it after rel_dly+1 cycles of request low.
    task automatic respond();
        if (t_rdy_out && !r_done_in) begin
            if (req_cnt >= req_dly) begin r_done_in = 1'b1; req_cnt = 0; end
            else req_cnt++;
        end else if (!t_rdy_out && r_done_in) begin
            if (rel_cnt >= rel_dly) begin r_done_in = 1'b0; rel_cnt = 0; end
            else rel_cnt++;
        end
    endtask

    initial begin
        int d0;
        int a0;
        int idx;

        // Reset with a pending request and low ack: nothing accepted.
        in_valid = 1'b1; in_data = 8'h3C;
        #1;
        check("in_ready_in_reset", 32'(in_ready), 32'(0));
        cycle();
        cycle();

        // Single transfer A5: ack rises 3 cycles after acceptance, held 4 cycles.
        rst_n = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
        d0 = done_seen;
        cycle();
        in_valid = 1'b0; in_data = 8'hFF;
        cycle(); cycle();
        r_done_in = 1'b1;
        repeat (4) cycle();
        r_done_in = 1'b0;
        cycle(); cycle();
        check("done_once", 32'(done_seen - d0), 32'(1));

        // Request phase timeout with no ack; then recovery to IDLE.
        in_valid = 1'b1; in_data = 8'hC3;
        cycle();
        in_valid = 1'b0;
        repeat (TIMEOUT) cycle();
        check("timeout_err", 32'(err), 32'(1));
        check("timeout_req_low", 32'(t_rdy_out), 32'(0));
        cycle();
        check("ready_after_timeout", 32'(in_ready), 32'(1));

        // Traffic still flows while err is set; then clear it.
        in_valid = 1'b1; in_data = 8'h11;
        cycle();
        in_valid = 1'b0;
        cycle();
        r_done_in = 1'b1; cycle();
        r_done_in = 1'b0; cycle();
        check("err_sticky", 32'(err), 32'(1));
        clr_err = 1'b1; cycle(); clr_err = 1'b0;
        check("err_cleared", 32'(err), 32'(0));

        // Ack arrives on the last permitted wait cycle: no error.
        in_valid = 1'b1; in_data = 8'h5E;
        cycle();
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) cycle();
        r_done_in = 1'b1; cycle();
        check("edge_ack_no_err", 32'(err), 32'(0));
        r_done_in = 1'b0; cycle();

        // Stale-high ack blocks acceptance until it falls.
        r_done_in = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        a0 = acc_seen;
        repeat (3) cycle();
        check("stale_blocks", 32'(data_out), 32'(8'h5E));
        r_done_in = 1'b0;
        cycle();
        check("accept_after_fall", 32'(acc_seen - a0), 32'(1));
        in_valid = 1'b0;
        cycle(); r_done_in = 1'b1; cycle(); r_done_in = 1'b0; cycle();

        // Back-to-back words 01,02,03 with a 2-cycle responder.
        d0 = done_seen; idx = 0; req_dly = 1; rel_dly = 1;
        in_valid = 1'b1; in_data = 8'h01;
        for (int c = 0; c < 80 && (done_seen - d0) < 3; c++) begin
            cycle();
            if (m_accept) begin
                idx++;
                if (idx < 3) in_data = 8'(idx + 1);
                else in_valid = 1'b0;
            end
            respond();
        end
        in_valid = 1'b0;
        check("b2b_done_count", 32'(done_seen - d0), 32'(3));
        cycle();

        // Reset while waiting for ack low: request stays low, no done.
        in_valid = 1'b1; in_data = 8'h99;
        cycle();
        in_valid = 1'b0; r_done_in = 1'b1;
        cycle();
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; cycle();
        check("post_reset_stale", 32'(in_ready), 32'(0));
        r_done_in = 1'b0; cycle();

        // Timeout coincident with clr_err leaves err set.
        in_valid = 1'b1; in_data = 8'h42;
        cycle();
        in_valid = 1'b0;
        repeat (TIMEOUT - 1) cycle();
        clr_err = 1'b1; cycle();
        check("set_beats_clear", 32'(err), 32'(1));
        clr_err = 1'b0; cycle();
        clr_err = 1'b1; cycle(); clr_err = 1'b0;

        // Randomized traffic with a well-behaved responder and stale-ack glitches.
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            clr_err  = ($urandom_range(0, 15) == 0);
            req_dly  = $urandom_range(0, 6);
            rel_dly  = $urandom_range(0, 6);
            if (!t_rdy_out && !r_done_in && !m_out && !m_rel && $urandom_range(0, 19) == 0)
                r_done_in = 1'b1;
            cycle();
            respond();
        end
        in_valid = 1'b0; clr_err = 1'b0;
        for (int c = 0; c < 40; c++) begin
            cycle();
            respond();
        end
        check("sb_drained", 32'(sb_q.size()), 32'(0));
        check("random_no_err", 32'(err), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_tx_ctrl.md
HANDSHAKE_TX_CTRL -- requirements
Module: handshake_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload width in bits.
REQ-002 Parameter TIMEOUT, default 255, range 2..65535, SHALL set the maximum wait in cycles per handshake phase.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on posedge clk.
REQ-005 in_valid  input  1  SHALL indicate that the requester presents a word on in_data.
REQ-006 in_data  input  DATA_W  SHALL be the payload, sampled only on acceptance.
REQ-007 in_ready  output  1  SHALL indicate that the controller can accept a word this cycle.
REQ-008 t_rdy_out  output  1  SHALL be the registered request level driven toward the receive domain's synchronizer.
REQ-009 data_out  output  DATA_W  SHALL be the latched payload, held stable whenever t_rdy_out=1.
REQ-010 r_done_in  input  1  SHALL be the acknowledge, already synchronized into clk by the team's 2-flop synchronizer.
REQ-011 done  output  1  SHALL pulse for one cycle on handshake completion.
REQ-012 err  output  1  SHALL be a sticky timeout flag.
REQ-013 clr_err  input  1  SHALL clear err on the next edge.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQ_HI, WAIT_LO, ERR_REL.
REQ-015 in_ready SHALL be 1 only in IDLE with r_done_in=0; a stale-high ack SHALL block acceptance.
REQ-016 Acceptance (in_valid & in_ready at edge N) SHALL latch in_data into data_out and, at N+1, show state=REQ_HI, t_rdy_out=1 and in_ready=0.
REQ-017 In REQ_HI, r_done_in=1 sampled at edge M SHALL give state=WAIT_LO and t_rdy_out=0 at M+1.
REQ-018 In WAIT_LO, r_done_in=0 sampled at edge K SHALL give state=IDLE, done=1 and in_ready=1 during cycle K+1; done SHALL be 0 at K+2.
REQ-019 The 16-bit wait counter SHALL clear on every state transition.
REQ-020 The wait counter SHALL increment each cycle spent in REQ_HI or WAIT_LO without the advancing condition.
REQ-021 If the counter equals TIMEOUT-1 and the advancing condition is absent, the next state SHALL be ERR_REL, with t_rdy_out=0 and err=1.
REQ-022 An advancing condition present in the same cycle as the timeout SHALL take priority, so no error is raised.
REQ-023 ERR_REL SHALL hold t_rdy_out=0 until r_done_in=0 is sampled, then return to IDLE with no done pulse.
REQ-024 ERR_REL SHALL NOT time out.
REQ-025 err SHALL remain 1 until clr_err=1 is sampled; err setting and clr_err in the same cycle SHALL resolve to err=1.
REQ-026 Acceptance SHALL be permitted while err=1; err does not block traffic.
REQ-027 data_out SHALL change only on acceptance.
REQ-028 in_data changes after acceptance SHALL have no effect.
REQ-029 in_valid held high across completion SHALL be accepted in the first eligible IDLE cycle, i.e. K+1 when r_done_in=0.
REQ-030 All outputs SHALL be driven from registers or from state decode only, with no combinational path from in_valid to t_rdy_out.

Reset
REQ-031 With rst_n=0 at an edge, the block SHALL be in IDLE, with t_rdy_out=0, done=0, err=0, data_out=0 and counter=0 after that edge.
REQ-032 During reset, in_ready SHALL be 0.
REQ-033 Reset asserted mid-handshake SHALL drop t_rdy_out at the next edge and SHALL NOT pulse done.
REQ-034 After reset, a still-high r_done_in SHALL hold in_ready=0 until it falls, as in REQ-015.

Structure
REQ-035 Package handshake_pkg SHALL hold the state enum (IDLE=0, REQ_HI=1, WAIT_LO=2, ERR_REL=3), the default DATA_W and TIMEOUT, and the counter width constant (16).
REQ-036 One sub-module, hs_timer, SHALL implement the clearable wait counter with its terminal-count compare.
REQ-037 The FSM, payload register and err flag SHALL reside in handshake_tx_ctrl.

Verification
REQ-038 Reset, then in_data=8'hA5 with in_valid for 1 cycle, and ack rising 3 cycles later and falling 4 cycles after that -> t_rdy_out high from N+1 until the cycle after ack is seen high; data_out=A5 throughout; done high exactly once; err=0.
REQ-039 TIMEOUT=16, no ack after acceptance -> t_rdy_out drops and err=1 exactly 16 cycles after entering REQ_HI; no done; in_ready=1 the cycle after the FSM returns to IDLE.
REQ-040 TIMEOUT=16, ack rises on exactly the 16th wait cycle -> WAIT_LO entered; err stays 0.
REQ-041 r_done_in held 1 while IDLE and in_valid=1 -> in_ready=0 and no acceptance; ack falls -> word accepted next edge.
REQ-042 Back-to-back: in_valid held with words 01, 02, 03 and a 2-cycle ack responder -> three done pulses; data_out sequence 01, 02, 03; no word lost or repeated.
REQ-043 rst_n=0 asserted in WAIT_LO -> t_rdy_out=0 and state IDLE next edge; no done; err=0; clr_err and timeout coincident -> err=1.
